// File: rtl/vref_cal_rx.sv
// vref_cal_rx: responder FSM for the MBTRAIN Vref calibration step.
// Optional per-wait-state timeout is enabled by defining VREF_CAL_RX_TIMEOUT_EN.
module vref_cal_rx #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [3:0]  i_decoded_sideband_message,
  input  logic        i_sideband_valid,
  input  logic        i_busy_negedge_detected,
  input  logic        i_valid_tx,
  input  logic        i_mainband_or_valtrain_test,
  input  logic [15:0] i_rx_lanes_result,
  output logic [3:0]  o_sideband_message,
  output logic        o_valid_rx,
  output logic        o_pt_en,
  output logic        o_mainband_or_valtrain_test,
  output logic [15:0] o_rx_lanes_result,
  output logic [4:0]  o_pass_count,
  output logic        o_test_ack,
  output logic        o_timeout
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    WAIT_START_REQ = 3'd1,
    TESTING        = 3'd2,
    END_RESP       = 3'd3,
    TEST_FINISHED  = 3'd4
  } state_t;

  state_t      cs, ns;
  logic        start_req, end_req, to_hit;
  logic [3:0]  msg_d;
  logic        valid_rx_d, pt_en_d, mvt_d, ack_d;
  logic [15:0] lanes_d;
  logic [4:0]  pass_d, lanes_pop;

  assign start_req = i_sideband_valid && (i_decoded_sideband_message == 4'b0001);
  assign end_req   = i_sideband_valid && (i_decoded_sideband_message == 4'b0011);

  always_comb begin
    lanes_pop = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      lanes_pop = lanes_pop + {4'b0000, i_rx_lanes_result[i]};
    end
  end

`ifdef VREF_CAL_RX_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        in_wait;

  assign in_wait = (cs == WAIT_START_REQ) || (cs == TESTING) || (cs == END_RESP);
  assign to_hit  = i_en && in_wait && (to_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           to_cnt <= '0;
    else if (cs != ns)    to_cnt <= '0;
    else if (in_wait)     to_cnt <= to_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           o_timeout <= 1'b0;
    else if (cs == IDLE)  o_timeout <= 1'b0;
    else if (to_hit)      o_timeout <= 1'b1;
  end
`else
  logic [15:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    ns      = cs;
    msg_d   = o_sideband_message;
    pt_en_d = o_pt_en;
    mvt_d   = o_mainband_or_valtrain_test;
    lanes_d = o_rx_lanes_result;
    pass_d  = o_pass_count;
    ack_d   = o_test_ack;

    // Disable wins over everything; outputs hold for one cycle and clear in IDLE.
    if (cs != IDLE && !i_en) begin
      ns = IDLE;
    end else if (to_hit) begin
      ns      = TEST_FINISHED;
      ack_d   = 1'b1;
      pt_en_d = 1'b0;
      msg_d   = '0;
    end else begin
      case (cs)
        IDLE: begin
          msg_d   = '0;
          pt_en_d = 1'b0;
          mvt_d   = 1'b0;
          lanes_d = '0;
          pass_d  = '0;
          ack_d   = 1'b0;
          if (i_en) ns = WAIT_START_REQ;
        end
        WAIT_START_REQ: if (start_req) begin
          ns      = TESTING;
          msg_d   = 4'b0010;
          pt_en_d = 1'b1;
          mvt_d   = i_mainband_or_valtrain_test;
        end
        TESTING: if (end_req) begin
          ns      = END_RESP;
          lanes_d = i_rx_lanes_result;
          pass_d  = lanes_pop;
          pt_en_d = 1'b0;
          msg_d   = 4'b0100;
        end
        END_RESP: if (i_busy_negedge_detected) begin
          ns    = TEST_FINISHED;
          ack_d = 1'b1;
          msg_d = '0;
        end
        TEST_FINISHED: ns = TEST_FINISHED;
        default: ns = IDLE;
      endcase
    end

    if ((ns == TESTING || ns == END_RESP) && (cs != ns))           valid_rx_d = 1'b1;
    else if (to_hit || (i_busy_negedge_detected && !i_valid_tx))  valid_rx_d = 1'b0;
    else                                                           valid_rx_d = o_valid_rx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs                          <= IDLE;
      o_sideband_message          <= '0;
      o_valid_rx                  <= 1'b0;
      o_pt_en                     <= 1'b0;
      o_mainband_or_valtrain_test <= 1'b0;
      o_rx_lanes_result           <= '0;
      o_pass_count                <= '0;
      o_test_ack                  <= 1'b0;
    end else begin
      cs                          <= ns;
      o_sideband_message          <= msg_d;
      o_valid_rx                  <= valid_rx_d;
      o_pt_en                     <= pt_en_d;
      o_mainband_or_valtrain_test <= mvt_d;
      o_rx_lanes_result           <= lanes_d;
      o_pass_count                <= pass_d;
      o_test_ack                  <= ack_d;
    end
  end

endmodule

// File: tb/tb_vref_cal_rx.sv
// Self-checking bench for vref_cal_rx: directed handshake scenarios plus
// randomized traffic against a cycle-level behavioural model of the responder.
module tb_vref_cal_rx;

`ifdef VREF_CAL_RX_TIMEOUT_EN
  localparam logic [15:0] TO    = 16'd16;
  localparam bit          TO_EN = 1'b1;
`else
  localparam logic [15:0] TO    = 16'd4096;
  localparam bit          TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic [3:0]  i_decoded_sideband_message;
  logic        i_sideband_valid;
  logic        i_busy_negedge_detected;
  logic        i_valid_tx;
  logic        i_mainband_or_valtrain_test;
  logic [15:0] i_rx_lanes_result;
  logic [3:0]  o_sideband_message;
  logic        o_valid_rx;
  logic        o_pt_en;
  logic        o_mainband_or_valtrain_test;
  logic [15:0] o_rx_lanes_result;
  logic [4:0]  o_pass_count;
  logic        o_test_ack;
  logic        o_timeout;

  always #5 clk = ~clk;

  vref_cal_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .i_en                        (i_en),
    .i_decoded_sideband_message  (i_decoded_sideband_message),
    .i_sideband_valid            (i_sideband_valid),
    .i_busy_negedge_detected     (i_busy_negedge_detected),
    .i_valid_tx                  (i_valid_tx),
    .i_mainband_or_valtrain_test (i_mainband_or_valtrain_test),
    .i_rx_lanes_result           (i_rx_lanes_result),
    .o_sideband_message          (o_sideband_message),
    .o_valid_rx                  (o_valid_rx),
    .o_pt_en                     (o_pt_en),
    .o_mainband_or_valtrain_test (o_mainband_or_valtrain_test),
    .o_rx_lanes_result           (o_rx_lanes_result),
    .o_pass_count                (o_pass_count),
    .o_test_ack                  (o_test_ack),
    .o_timeout                   (o_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: handshake phase (0 idle, 1 awaiting start, 2 testing,
  // 3 end response pending, 4 finished) plus dwell time in the current phase.
  int          ph, dwell;
  logic [3:0]  e_msg;
  logic        e_vrx, e_pt, e_mvt, e_ack, e_to;
  logic [15:0] e_lanes;
  logic [4:0]  e_pass;

  task automatic model_reset();
    ph = 0; dwell = 0;
    e_msg = '0; e_vrx = 0; e_pt = 0; e_mvt = 0; e_ack = 0; e_to = 0;
    e_lanes = '0; e_pass = '0;
  endtask

  task automatic model_step();
    int nph;
    bit start_ok, end_ok, to_fire;
    nph      = ph;
    start_ok = i_sideband_valid && (i_decoded_sideband_message == 4'd1);
    end_ok   = i_sideband_valid && (i_decoded_sideband_message == 4'd3);
    to_fire  = TO_EN && i_en && (ph >= 1) && (ph <= 3) && (dwell == int'(TO) - 1);
    if (ph == 0) begin
      e_msg = '0; e_pt = 0; e_mvt = 0; e_lanes = '0; e_pass = '0; e_ack = 0; e_to = 0;
      if (i_en) nph = 1;
    end else if (!i_en) begin
      nph = 0;
    end else if (to_fire) begin
      nph = 4; e_ack = 1; e_to = 1; e_pt = 0; e_msg = '0;
    end else if (ph == 1 && start_ok) begin
      nph = 2; e_msg = 4'd2; e_pt = 1; e_mvt = i_mainband_or_valtrain_test;
    end else if (ph == 2 && end_ok) begin
      nph = 3; e_lanes = i_rx_lanes_result; e_pass = 5'($countones(i_rx_lanes_result));
      e_pt = 0; e_msg = 4'd4;
    end else if (ph == 3 && i_busy_negedge_detected) begin
      nph = 4; e_ack = 1; e_msg = '0;
    end
    if ((nph == 2 || nph == 3) && nph != ph) e_vrx = 1;
    else if (to_fire)                       e_vrx = 0;
    else if (i_busy_negedge_detected && !i_valid_tx) e_vrx = 0;
    if (nph != ph)                 dwell = 0;
    else if (ph >= 1 && ph <= 3)   dwell = dwell + 1;
    ph = nph;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_msg"},   o_sideband_message, e_msg);
    check_eq({tag, "_vrx"},   o_valid_rx, e_vrx);
    check_eq({tag, "_pt"},    o_pt_en, e_pt);
    check_eq({tag, "_mvt"},   o_mainband_or_valtrain_test, e_mvt);
    check_eq({tag, "_lanes"}, o_rx_lanes_result, e_lanes);
    check_eq({tag, "_pass"},  o_pass_count, e_pass);
    check_eq({tag, "_ack"},   o_test_ack, e_ack);
    check_eq({tag, "_to"},    o_timeout, e_to);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_outputs(tag);
  endtask

  task automatic quiet();
    i_decoded_sideband_message  = '0;
    i_sideband_valid            = 0;
    i_busy_negedge_detected     = 0;
    i_valid_tx                  = 0;
    i_mainband_or_valtrain_test = 0;
    i_rx_lanes_result           = '0;
  endtask

  task automatic send(input logic [3:0] m);
    i_decoded_sideband_message = m;
    i_sideband_valid           = 1;
  endtask

  bit en_r;
  int r;

  initial begin
    rst_n = 0; i_en = 0;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1;

    // Nominal handshake with valtrain latch and repeated start in TESTING
    i_en = 1;
    tick("enter_wait");
    send(4'd1); i_mainband_or_valtrain_test = 1;
    tick("start");
    check_eq("start_resp_msg", o_sideband_message, 4'b0010);
    check_eq("start_vrx", o_valid_rx, 1);
    check_eq("start_pt_en", o_pt_en, 1);
    quiet();
    tick("testing_idle");
    check_eq("mvt_latched", o_mainband_or_valtrain_test, 1);
    send(4'd1);
    tick("dup_start");
    check_eq("dup_start_msg", o_sideband_message, 4'b0010);
    send(4'd3); i_rx_lanes_result = 16'hF0F1;
    tick("end");
    check_eq("end_resp_msg", o_sideband_message, 4'b0100);
    check_eq("end_lanes", o_rx_lanes_result, 16'hF0F1);
    check_eq("end_pass", o_pass_count, 5'd9);
    check_eq("end_pt_off", o_pt_en, 0);
    check_eq("end_ack_low", o_test_ack, 0);
    quiet(); i_busy_negedge_detected = 1; i_valid_tx = 1;
    tick("busy_tx_owned");
    check_eq("ack_after_negedge", o_test_ack, 1);
    check_eq("vrx_held_tx_owned", o_valid_rx, 1);
    i_valid_tx = 0;
    tick("busy_tx_free");
    check_eq("vrx_cleared", o_valid_rx, 0);
    check_eq("mvt_in_finished", o_mainband_or_valtrain_test, 1);
    quiet();
    tick("finished_hold");
    i_en = 0;
    tick("disable_1");
    check_eq("disable_hold_ack", o_test_ack, 1);
    tick("disable_2");
    check_eq("disable_clear_ack", o_test_ack, 0);

    // Unexpected end req in WAIT_START_REQ, then abort in TESTING
    i_en = 1;
    tick("enter_wait2");
    send(4'd3);
    tick("early_end");
    check_eq("early_end_vrx", o_valid_rx, 0);
    check_eq("early_end_msg", o_sideband_message, 4'b0000);
    send(4'd1);
    tick("start2");
    quiet(); i_en = 0;
    tick("abort_1");
    check_eq("abort_pt_held", o_pt_en, 1);
    tick("abort_2");
    check_eq("abort_pt_clear", o_pt_en, 0);
    check_eq("abort_msg_clear", o_sideband_message, 4'b0000);
    i_busy_negedge_detected = 1;
    tick("idle_busy");
    quiet();

    // Timeout while waiting for start req
    i_en = 1;
    tick("enter_wait3");
    for (int k = 0; k < 15; k++) tick("to_wait");
    check_eq("to_not_yet", o_timeout, 0);
    tick("to_fire");
    check_eq("to_flag", o_timeout, TO_EN);
    check_eq("to_ack", o_test_ack, TO_EN);
    i_en = 0;
    tick("to_dis1");
    tick("to_dis2");

    // Asynchronous reset in TESTING
    i_en = 1;
    tick("enter_wait4");
    send(4'd1);
    tick("start4");
    quiet();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check_eq("async_rst_vrx", o_valid_rx, 0);
    @(posedge clk);
    #1 rst_n = 1;
    tick("post_rst");

    // Randomized traffic
    en_r = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 23) == 0) en_r = ~en_r;
      i_en = en_r;
      r = $urandom_range(0, 9);
      i_sideband_valid = (r < 4);
      i_decoded_sideband_message = (r < 2) ? 4'd1 : (r < 4) ? 4'd3 : 4'($urandom_range(0, 15));
      i_busy_negedge_detected = ($urandom_range(0, 4) == 0);
      i_valid_tx = $urandom_range(0, 1) == 1;
      i_mainband_or_valtrain_test = $urandom_range(0, 1) == 1;
      i_rx_lanes_result = 16'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
